mem_lsu: RTL and testbench

- Load/store unit of the MEM stage, directly downstream of the EX/MEM pipeline register.
- Consumes the registered address (ALU result), the forwarded rs2 store data, the memory control bits and funct3.
- Runs a request/response handshake to data memory and stalls the pipeline while an access is in flight.
- Presents the aligned, sign/zero-extended load result to the MEM/WB register.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/lsu_align.sv | 49 ++++
 rtl/mem_lsu.sv | 167 ++++++++++++++++
 tb/tb_mem_lsu.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared funct3 codes, LSU state encoding and alignment helper
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // Clears the address bits below the access size so the access lands naturally aligned.
    function automatic logic [1:0] lsu_force_align(input logic [2:0] funct3, input logic [1:0] lo);
        if (funct3[1:0] == F3_B[1:0]) begin
            return lo;
        end else if (funct3[1:0] == F3_H[1:0]) begin
            return {lo[1], 1'b0};
        end
        return 2'b00;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane replication/byte enables and load extraction/extension
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_misaligned
);

    logic        is_byte;
    logic        is_half;
    logic [31:0] shifted;

    assign is_byte = (i_funct3[1:0] == F3_B[1:0]);
    assign is_half = (i_funct3[1:0] == F3_H[1:0]);
    assign shifted = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_misaligned = (is_half & i_addr_lo[0]) | (~is_byte & ~is_half & (i_addr_lo != 2'b00));
        o_wmask      = 4'b1111;
        o_wdata      = i_store_data;
        if (is_byte) begin
            o_wmask = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_store_data[7:0]}};
        end else if (is_half) begin
            o_wmask = 4'b0011 << i_addr_lo;
            o_wdata = {2{i_store_data[15:0]}};
        end
    end

    // Reserved encodings fall through to the word case.
    always_comb begin
        o_load_data = shifted;
        case (i_funct3)
            F3_B:    o_load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   o_load_data = {24'h0, shifted[7:0]};
            F3_H:    o_load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   o_load_data = {16'h0, shifted[15:0]};
            F3_W:    o_load_data = shifted;
            default: o_load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit: request/response handshake, pipeline stall, load formatting
module mem_lsu
    import riscv_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter bit TRAP_MISALIGNED = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_store_data,
    output logic              o_stall,
    output logic              o_done,
    output logic [31:0]       o_load_data,
    output logic              o_misaligned,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [31:0]       o_dmem_wdata,
    output logic [3:0]        o_dmem_wmask,
    input  logic              i_dmem_ready,
    input  logic              i_dmem_rvalid,
    input  logic [31:0]       i_dmem_rdata
);

    lsu_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [31:0]       load_q, load_d;
    logic              mis_q, mis_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        lo_q, lo_d;

    logic              mem_op;
    logic              in_idle;
    logic [2:0]        f3_sel;
    logic [1:0]        lo_raw;
    logic [1:0]        lo_eff;
    logic [3:0]        al_wmask;
    logic [31:0]       al_wdata;
    logic [31:0]       al_load;
    logic              al_misaligned;
    logic              mis_hit;

    assign mem_op  = i_valid & (i_mem_read | i_mem_write);
    assign in_idle = (state_q == LSU_IDLE);

    // In IDLE the aligner sees the live instruction; afterwards it formats the captured load.
    assign f3_sel  = in_idle ? i_funct3 : funct3_q;
    assign lo_raw  = in_idle ? i_addr[1:0] : lo_q;
    assign lo_eff  = TRAP_MISALIGNED ? lo_raw : lsu_force_align(f3_sel, lo_raw);
    assign mis_hit = TRAP_MISALIGNED & al_misaligned;

    lsu_align u_align (
        .i_funct3     (f3_sel),
        .i_addr_lo    (lo_eff),
        .i_store_data (i_store_data),
        .i_rdata      (i_dmem_rdata),
        .o_wmask      (al_wmask),
        .o_wdata      (al_wdata),
        .o_load_data  (al_load),
        .o_misaligned (al_misaligned)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        load_d   = load_q;
        mis_d    = mis_q;
        funct3_d = funct3_q;
        lo_d     = lo_q;
        o_stall  = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (mem_op) begin
                    o_stall = 1'b1;
                    if (mis_hit) begin
                        state_d = LSU_DONE;
                        mis_d   = 1'b1;
                    end else begin
                        state_d  = LSU_REQ;
                        req_d    = 1'b1;
                        we_d     = i_mem_write;
                        addr_d   = {i_addr[ADDR_W-1:2], 2'b00};
                        wmask_d  = al_wmask;
                        wdata_d  = al_wdata;
                        funct3_d = i_funct3;
                        lo_d     = lo_eff;
                    end
                end
            end
            LSU_REQ: begin
                o_stall = 1'b1;
                if (i_dmem_ready) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d = LSU_DONE;
                    end else if (i_dmem_rvalid) begin
                        load_d  = al_load;
                        state_d = LSU_DONE;
                    end else begin
                        state_d = LSU_RESP;
                    end
                end
            end
            LSU_RESP: begin
                o_stall = 1'b1;
                if (i_dmem_rvalid) begin
                    load_d  = al_load;
                    state_d = LSU_DONE;
                end
            end
            LSU_DONE: begin
                state_d = LSU_IDLE;
                mis_d   = 1'b0;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= LSU_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            load_q   <= '0;
            mis_q    <= 1'b0;
            funct3_q <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            load_q   <= load_d;
            mis_q    <= mis_d;
            funct3_q <= funct3_d;
            lo_q     <= lo_d;
        end
    end

    assign o_done       = (state_q == LSU_DONE);
    assign o_misaligned = mis_q;
    assign o_load_data  = load_q;
    assign o_dmem_req   = req_q;
    assign o_dmem_we    = we_q;
    assign o_dmem_addr  = addr_q;
    assign o_dmem_wdata = wdata_q;
    assign o_dmem_wmask = wmask_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - self-checking bench for mem_lsu: directed vector table, corner sequences, random ops
module tb_mem_lsu;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_store_data;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_load_data;
    logic        o_misaligned;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_wmask;
    logic        i_dmem_ready;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;

    always #5 i_clk = ~i_clk;

    mem_lsu #(.ADDR_W(32), .TRAP_MISALIGNED(1'b1)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .i_mem_read    (i_mem_read),
        .i_mem_write   (i_mem_write),
        .i_funct3      (i_funct3),
        .i_addr        (i_addr),
        .i_store_data  (i_store_data),
        .o_stall       (o_stall),
        .o_done        (o_done),
        .o_load_data   (o_load_data),
        .o_misaligned  (o_misaligned),
        .o_dmem_req    (o_dmem_req),
        .o_dmem_we     (o_dmem_we),
        .o_dmem_addr   (o_dmem_addr),
        .o_dmem_wdata  (o_dmem_wdata),
        .o_dmem_wmask  (o_dmem_wmask),
        .i_dmem_ready  (i_dmem_ready),
        .i_dmem_rvalid (i_dmem_rvalid),
        .i_dmem_rdata  (i_dmem_rdata)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] held_load;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdw;
        int          rdy;
        int          rv;
        logic        mis;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [31:0] load;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: byte-lane arithmetic on access size and offset.
    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] addr);
        return (int'(addr[1:0]) % acc_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] m;
        int off, sz;
        off = int'(addr[1:0]);
        sz  = acc_size(f3);
        for (int b = 0; b < 4; b++) m[b] = (b >= off) && (b < off + sz);
        return m;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] w;
        int sz;
        sz = acc_size(f3);
        for (int b = 0; b < 4; b++) w[8*b +: 8] = sd[8*(b % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdw);
        logic [31:0] v;
        int off, sz;
        off = int'(addr[1:0]);
        sz  = acc_size(f3);
        v   = 32'h0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = rdw[8*(off + i) +: 8];
        if (!f3[2] && sz < 4 && v[8*sz-1]) begin
            for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    // Drives one instruction from a negedge and plays the memory side until o_done.
    task automatic run_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdw,
                          input int rdy_dly, input int rv_dly, input logic exp_mis,
                          input logic [3:0] exp_mask, input logic [31:0] exp_wdata, input logic [31:0] exp_load);
        int          stalls, reqc, waitc, bus_err, exp_stall;
        logic        accepted, got_done, mis_seen, is_load;
        logic [31:0] ld_seen, want_load;
        stalls = 0; reqc = 0; waitc = 0; bus_err = 0;
        accepted = 1'b0; got_done = 1'b0; mis_seen = 1'b0; ld_seen = 32'h0;
        is_load   = rd & ~wr;
        want_load = (is_load && !exp_mis) ? exp_load : held_load;
        exp_stall = exp_mis ? 1 : 2 + rdy_dly + ((is_load && rv_dly > 0) ? rv_dly : 0);

        i_valid = 1'b1; i_mem_read = rd; i_mem_write = wr; i_funct3 = f3;
        i_addr = addr; i_store_data = sd;
        i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0;
        for (int c = 0; c < 60 && !got_done; c++) begin
            #1;
            if (o_stall) stalls++;
            if (o_done) begin
                got_done = 1'b1;
                mis_seen = o_misaligned;
                ld_seen  = o_load_data;
                i_valid = 1'b0;
                i_dmem_rvalid = 1'b1;
                i_dmem_rdata = $urandom;
            end else begin
                i_dmem_ready = 1'b0;
                i_dmem_rvalid = 1'b0;
                i_dmem_rdata = $urandom;
                if (o_dmem_req) begin
                    if (o_dmem_addr !== (addr & ~32'd3) || o_dmem_we !== wr ||
                        o_dmem_wmask !== exp_mask || o_dmem_wdata !== exp_wdata) bus_err++;
                    if (!is_load) i_dmem_rvalid = 1'($urandom % 2);
                    if (reqc == rdy_dly) begin
                        i_dmem_ready = 1'b1;
                        accepted = 1'b1;
                        if (is_load && rv_dly == 0) begin
                            i_dmem_rvalid = 1'b1;
                            i_dmem_rdata = rdw;
                        end
                    end
                    reqc++;
                end else if (accepted && is_load) begin
                    waitc++;
                    if (waitc == rv_dly) begin
                        i_dmem_rvalid = 1'b1;
                        i_dmem_rdata = rdw;
                    end
                end
            end
            @(negedge i_clk);
        end
        i_dmem_ready = 1'b0;
        chk({tag, " done_seen"}, 32'(got_done), 32'd1);
        chk({tag, " stall_cycles"}, stalls, exp_stall);
        chk({tag, " req_cycles"}, reqc, exp_mis ? 0 : rdy_dly + 1);
        chk({tag, " bus_fields"}, bus_err, 0);
        chk({tag, " misaligned"}, 32'(mis_seen), 32'(exp_mis));
        chk({tag, " load_data"}, ld_seen, want_load);
        #1;
        chk({tag, " pulse_end"}, {30'h0, o_done, o_stall}, 32'h0);
        @(negedge i_clk);
        i_dmem_rvalid = 1'b0;
        #1;
        chk({tag, " load_held"}, o_load_data, want_load);
        held_load = want_load;
        @(negedge i_clk);
    endtask

    task automatic run_model(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdw,
                             input int rdy_dly, input int rv_dly);
        run_op(tag, rd, wr, f3, addr, sd, rdw, rdy_dly, rv_dly, model_mis(f3, addr),
               model_mask(f3, addr), model_wdata(f3, sd), model_load(f3, addr, rdw));
    endtask

    task automatic idle_check(input string tag, input logic v, input logic rd, input logic wr);
        int err;
        err = 0;
        i_valid = v; i_mem_read = rd; i_mem_write = wr;
        i_funct3 = 3'b010; i_addr = 32'h400; i_store_data = $urandom;
        for (int c = 0; c < 3; c++) begin
            i_dmem_rvalid = 1'b1; i_dmem_rdata = $urandom;
            #1;
            if (o_stall !== 1'b0 || o_dmem_req !== 1'b0 || o_done !== 1'b0 || o_load_data !== held_load) err++;
            @(negedge i_clk);
        end
        i_valid = 1'b0; i_dmem_rvalid = 1'b0;
        chk({tag, " idle_quiet"}, err, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int err;
        logic rd, wr;
        int kind;
        tbl[0]  = '{1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        0, 0, 1'b0, 4'h8, 32'hA5A5A5A5, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 3'b000, 32'h102, 32'h0,        32'h12F45678, 0, 0, 1'b0, 4'h4, 32'h0,        32'hFFFFFFF4};
        tbl[3]  = '{1'b1, 1'b0, 3'b100, 32'h102, 32'h0,        32'h12F45678, 0, 1, 1'b0, 4'h4, 32'h0,        32'h000000F4};
        tbl[4]  = '{1'b1, 1'b0, 3'b001, 32'h101, 32'h0,        32'h11223344, 0, 0, 1'b1, 4'h0, 32'h0,        32'h0};
        tbl[5]  = '{1'b1, 1'b0, 3'b010, 32'h200, 32'h0,        32'hCAFEF00D, 3, 2, 1'b0, 4'hF, 32'h0,        32'hCAFEF00D};
        tbl[6]  = '{1'b0, 1'b1, 3'b001, 32'h102, 32'hBEEF1234, 32'h0,        1, 0, 1'b0, 4'hC, 32'h12341234, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80017FFF, 2, 0, 1'b0, 4'hC, 32'h0,        32'hFFFF8001};
        tbl[8]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0,        32'h80017FFF, 0, 3, 1'b0, 4'h3, 32'h0,        32'h00007FFF};
        tbl[9]  = '{1'b1, 1'b0, 3'b110, 32'h104, 32'h0,        32'h89ABCDEF, 1, 1, 1'b0, 4'hF, 32'h0,        32'h89ABCDEF};
        tbl[10] = '{1'b0, 1'b1, 3'b010, 32'h102, 32'h11111111, 32'h0,        0, 0, 1'b1, 4'h0, 32'h0,        32'h0};
        tbl[11] = '{1'b1, 1'b1, 3'b000, 32'h109, 32'h0000003C, 32'h0,        0, 0, 1'b0, 4'h2, 32'h3C3C3C3C, 32'h0};

        i_rst_n = 1'b0; i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
        i_funct3 = 3'b0; i_addr = 32'h0; i_store_data = 32'h0;
        i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'h0;
        held_load = 32'h0;
        repeat (3) @(negedge i_clk);
        #1;
        chk("reset req_we", {30'h0, o_dmem_req, o_dmem_we}, 32'h0);
        chk("reset addr", o_dmem_addr, 32'h0);
        chk("reset wdata_mask", o_dmem_wdata | {28'h0, o_dmem_wmask}, 32'h0);
        chk("reset load", o_load_data, 32'h0);
        chk("reset done_mis_stall", {29'h0, o_done, o_misaligned, o_stall}, 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].sd,
                   tbl[i].rdw, tbl[i].rdy, tbl[i].rv, tbl[i].mis, tbl[i].mask, tbl[i].wdata, tbl[i].load);
        end

        idle_check("no_memop", 1'b1, 1'b0, 1'b0);
        idle_check("invalid_slot", 1'b0, 1'b1, 1'b1);

        // Reset while a load waits in RESP; a late response must be dropped.
        i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_funct3 = 3'b010;
        i_addr = 32'h300; i_store_data = 32'h0;
        @(negedge i_clk);
        #1;
        chk("rstseq req_up", 32'(o_dmem_req), 32'd1);
        i_dmem_ready = 1'b1; i_dmem_rvalid = 1'b0;
        @(negedge i_clk);
        i_dmem_ready = 1'b0;
        #1;
        chk("rstseq in_resp", {30'h0, o_dmem_req, o_stall}, 32'h1);
        i_valid = 1'b0; i_mem_read = 1'b0;
        i_rst_n = 1'b0;
        #1;
        chk("rstseq req_drop", {30'h0, o_dmem_req, o_dmem_we}, 32'h0);
        chk("rstseq bus_zero", o_dmem_addr | o_dmem_wdata | {28'h0, o_dmem_wmask}, 32'h0);
        chk("rstseq flags", {29'h0, o_done, o_misaligned, o_stall}, 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        held_load = 32'h0;
        err = 0;
        for (int c = 0; c < 4; c++) begin
            i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h55AA55AA;
            #1;
            if (o_done !== 1'b0 || o_load_data !== 32'h0 || o_dmem_req !== 1'b0) err++;
            @(negedge i_clk);
        end
        i_dmem_rvalid = 1'b0;
        chk("rstseq late_rvalid_ignored", err, 0);

        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom % 4);
            rd = (kind != 1);
            wr = (kind == 1) || (kind == 2);
            run_model($sformatf("rnd%0d", n), rd, wr, 3'($urandom % 8), $urandom, $urandom, $urandom,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
